demux_1_to_8_buf: RTL

- 32-bit 1-to-8 demultiplexer with one holding register per output channel; the distributing counterpart of the team's 8-to-1 select mux.
- Routes each accepted input word to output channel `sel`, where it is held until that channel's consumer acknowledges it.
- Sits between a single producer (datapath result bus) and eight independent consumers.
- Also reports channel occupancy.

---
 rtl/demux_1_to_8_buf.sv | 98 +++++++++
 1 files changed

// File: rtl/demux_1_to_8_buf.sv
// 1-to-8 demux: each accepted word lands in a per-channel holding register until that channel's consumer acks it.
// Latency 1 cycle from accept to d_out/out_valid. in_ready drops only while the selected channel is full and not being acked.
// Optional DEMUX_AUTO_SEL_EN: sel is ignored and a round-robin pointer (exposed on rr_ptr_o) picks the channel.
module demux_1_to_8_buf #(
    parameter int DW  = 32,
    parameter int NCH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     d_in,
    input  logic [2:0]        sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NCH*DW-1:0] d_out,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ack,
    output logic [3:0]        occ_cnt
`ifdef DEMUX_AUTO_SEL_EN
    ,
    output logic [2:0]        rr_ptr_o
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

    ch_state_t             state_q [NCH];
    ch_state_t             state_d [NCH];
    logic [NCH-1:0][DW-1:0] data_q;
    logic [NCH-1:0][DW-1:0] data_d;
    logic [3:0]            occ_q;
    logic [3:0]            occ_d;
    logic [2:0]            act_sel;
    logic                  accept;

`ifdef DEMUX_AUTO_SEL_EN
    logic [2:0] rr_ptr_q;
    logic [2:0] rr_ptr_d;
    logic       unused_sel;

    assign unused_sel = ^sel;
    assign act_sel    = rr_ptr_q;
    assign rr_ptr_d   = rr_ptr_q + {2'b00, accept};
    assign rr_ptr_o   = rr_ptr_q;
`else
    assign act_sel = sel;
`endif

    // An ack on the selected channel frees its slot in the same cycle, giving 1 word/cycle throughput.
    assign in_ready = !reset && ((state_q[act_sel] == EMPTY) || out_ack[act_sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept && (act_sel == 3'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = d_in;
            end else if ((state_q[k] == FULL) && out_ack[k]) begin
                state_d[k] = EMPTY;
            end
            occ_d = occ_d + {3'b000, (state_d[k] == FULL)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= EMPTY;
            end
            data_q <= '0;
            occ_q  <= '0;
`ifdef DEMUX_AUTO_SEL_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
            end
            data_q <= data_d;
            occ_q  <= occ_d;
`ifdef DEMUX_AUTO_SEL_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign d_out   = data_q;
    assign occ_cnt = occ_q;

endmodule
